// File: rtl/concat_sched_if.sv
// concat_sched bus bundle: requester beats on one side, packer feed on the other.
// master drives requests and the stall; slave is the scheduler itself.
interface concat_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [64*NUM_REQ-1:0] req_data;
  logic [7*NUM_REQ-1:0]  req_bits;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  out_stall;
  logic [63:0]           pk_data;
  logic [6:0]            pk_valid_bits;
  logic                  pk_msg_fin;
  logic                  pk_stall;
  logic [2:0]            grant_id;
  logic                  busy;
  logic                  msg_done;
  logic [CNT_W-1:0]      msg_bits;
  logic                  err_len;

  modport master (
    output req_valid, req_data, req_bits, req_last, out_stall,
    input  req_ready, pk_data, pk_valid_bits, pk_msg_fin,
    input  pk_stall, grant_id, busy, msg_done, msg_bits, err_len
  );

  modport slave (
    input  req_valid, req_data, req_bits, req_last, out_stall,
    output req_ready, pk_data, pk_valid_bits, pk_msg_fin,
    output pk_stall, grant_id, busy, msg_done, msg_bits, err_len
  );
endinterface

// File: rtl/concat_sched.sv
// concat_sched: round-robin message scheduler in front of a shift-concat packer.
// A grant covers one whole message, then the packer is flushed and drained.
module concat_sched #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input logic           clk,
  input logic           rst,
  concat_sched_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd1;
  localparam logic [1:0] S_FIN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [7:0] DRAIN_LD = 8'(DRAIN_CYC - 1);
  localparam logic [2:0] LAST_ID  = 3'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [2:0]       gid;
  logic [2:0]       ptr;
  logic [7:0]       dcnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] mbits;
  logic [63:0]      pdata;
  logic [6:0]       pvb;
  logic             pfin;
  logic             done;
  logic             err;

  logic               stall;
  logic               any;
  logic               hit_hi;
  logic               hit_lo;
  logic [2:0]         pick_hi;
  logic [2:0]         pick_lo;
  logic [2:0]         pick;
  logic               sel_valid;
  logic               sel_last;
  logic [63:0]        sel_data;
  logic [6:0]         sel_bits;
  logic [63:0]        mask;
  logic [CNT_W:0]     sum;
  logic [NUM_REQ-1:0] ready;

  assign stall = bus.out_stall;

  // Two scans: indices at/after the pointer win over the wrapped ones.
  always_comb begin
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    pick_hi = '0;
    pick_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (3'(i) >= ptr) begin
          hit_hi  = 1'b1;
          pick_hi = 3'(i);
        end else begin
          hit_lo  = 1'b1;
          pick_lo = 3'(i);
        end
      end
    end
    any  = hit_hi | hit_lo;
    pick = hit_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_bits  = '0;
    ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid == 3'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[64*i +: 64];
        sel_bits  = bus.req_bits[7*i +: 7];
        ready[i]  = (state == S_XFER) && !stall;
      end
    end
  end

  assign mask = (sel_bits >= 7'd64) ? '1
              : ((64'd1 << sel_bits) - 64'd1);
  assign sum  = {1'b0, cnt} + (CNT_W+1)'(sel_bits);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      gid   <= '0;
      ptr   <= '0;
      dcnt  <= '0;
      cnt   <= '0;
      mbits <= '0;
      pdata <= '0;
      pvb   <= '0;
      pfin  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else if (!stall) begin
      pdata <= '0;
      pvb   <= '0;
      pfin  <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (any) begin
            gid   <= pick;
            state <= S_XFER;
          end
        end
        S_XFER: begin
          if (sel_valid) begin
            if (sel_bits > 7'd64) begin
              err <= 1'b1;
            end else begin
              pdata <= sel_data & mask;
              pvb   <= sel_bits;
              cnt   <= sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
            end
            if (sel_last) state <= S_FIN;
          end
        end
        S_FIN: begin
          pfin  <= 1'b1;
          done  <= 1'b1;
          mbits <= cnt;
          cnt   <= '0;
          dcnt  <= DRAIN_LD;
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (dcnt == 8'd0) begin
            ptr   <= (gid == LAST_ID) ? 3'd0 : gid + 3'd1;
            state <= S_IDLE;
          end else begin
            dcnt <= dcnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = ready;
  assign bus.pk_stall      = stall;
  assign bus.pk_data       = pdata;
  assign bus.pk_valid_bits = pvb;
  assign bus.pk_msg_fin    = pfin;
  assign bus.grant_id      = gid;
  assign bus.busy          = (state != S_IDLE);
  assign bus.msg_done      = done;
  assign bus.msg_bits      = mbits;
  assign bus.err_len       = err;
endmodule

// File: tb/tb_concat_sched.sv
// Bench for concat_sched: requester beat queues, a message-level model
// of grants/drain timing, and per-cycle output comparison.
module tb_concat_sched;
  localparam int N  = 4;
  localparam int CW = 16;
  localparam int DC = 3;

  typedef struct {
    logic [63:0] d;
    int          b;
    bit          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  concat_sched_if #(.NUM_REQ(N), .CNT_W(CW)) bus ();

  concat_sched #(.NUM_REQ(N), .CNT_W(CW), .DRAIN_CYC(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t q [N][$];
  bit [N-1:0] gate;
  logic [N-1:0] vld;
  bit stall_in;
  bit rst_in;
  bit last_stall;

  int m_owner;
  int m_quiet;
  int m_ptr;
  bit m_ending;
  longint m_sum;
  logic [63:0] e_data;
  logic [6:0]  e_vb;
  bit e_fin;
  bit e_done;
  bit e_err;
  logic [2:0]  e_gid;
  logic [CW-1:0] e_mbits;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int log_vb[$];
  int log_vbc[$];
  int done_gid[$];
  int done_bits[$];
  int done_cyc[$];
  int fin_cnt;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] keep_low(logic [63:0] d, int n);
    if (n <= 0) return 64'd0;
    return (d << (64 - n)) >> (64 - n);
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_owner >= 0 && !m_ending && !stall_in) r[m_owner] = 1'b1;
    return r;
  endfunction

  task automatic push(int r, int b, bit l);
    beat_t x;
    x.d = {$urandom, $urandom};
    x.b = b;
    x.l = l;
    q[r].push_back(x);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      vld[i] = gate[i] && (q[i].size() > 0);
      if (vld[i]) begin
        bus.req_data[64*i +: 64] = q[i][0].d;
        bus.req_bits[7*i +: 7]   = 7'(q[i][0].b);
        bus.req_last[i]          = q[i][0].l;
      end else begin
        bus.req_data[64*i +: 64] = '0;
        bus.req_bits[7*i +: 7]   = '0;
        bus.req_last[i]          = 1'b0;
      end
    end
    bus.req_valid = vld;
    bus.out_stall = stall_in;
    rst = rst_in;
  endtask

  // Message-level view: a grant runs until the last beat, then 1 flush
  // cycle plus DC drain cycles pass before anyone is arbitrated again.
  task automatic model_step();
    beat_t b;
    bit found;
    int idx;
    last_stall = stall_in && !rst_in;
    if (rst_in) begin
      m_owner = -1; m_quiet = 0; m_ptr = 0; m_ending = 0; m_sum = 0;
      e_data = '0; e_vb = '0; e_fin = 0; e_done = 0; e_err = 0;
      e_gid = '0; e_mbits = '0;
      return;
    end
    if (stall_in) return;
    e_data = '0; e_vb = '0; e_fin = 0; e_done = 0;
    if (m_owner >= 0 && !m_ending) begin
      if (vld[m_owner]) begin
        b = q[m_owner].pop_front();
        if (b.b > 64) begin
          e_err = 1;
        end else begin
          e_vb   = 7'(b.b);
          e_data = keep_low(b.d, b.b);
          m_sum  = m_sum + b.b;
          if (m_sum > (2**CW - 1)) m_sum = 2**CW - 1;
        end
        if (b.l) begin
          m_ending = 1;
          m_quiet  = DC + 1;
        end
      end
    end else if (m_ending) begin
      if (m_quiet == DC + 1) begin
        e_fin = 1; e_done = 1; e_mbits = CW'(m_sum); m_sum = 0;
      end
      m_quiet--;
      if (m_quiet == 0) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_ending = 0;
      end
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && vld[idx]) begin
          found = 1;
          m_owner = idx;
          e_gid = 3'(idx);
        end
      end
    end
  endtask

  task automatic cycle();
    drive();
    #1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready()));
    chk("pk_stall", 64'(bus.pk_stall), 64'(stall_in));
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("pk_data", bus.pk_data, e_data);
    chk("pk_valid_bits", 64'(bus.pk_valid_bits), 64'(e_vb));
    chk("pk_msg_fin", 64'(bus.pk_msg_fin), 64'(e_fin));
    chk("grant_id", 64'(bus.grant_id), 64'(e_gid));
    chk("busy", 64'(bus.busy), 64'(m_owner >= 0));
    chk("msg_done", 64'(bus.msg_done), 64'(e_done));
    chk("msg_bits", 64'(bus.msg_bits), 64'(e_mbits));
    chk("err_len", 64'(bus.err_len), 64'(e_err));
    if (!last_stall) begin
      if (bus.pk_valid_bits != 0) begin
        log_vb.push_back(int'(bus.pk_valid_bits));
        log_vbc.push_back(cyc);
      end
      if (bus.pk_msg_fin) fin_cnt++;
      if (bus.msg_done) begin
        done_gid.push_back(int'(bus.grant_id));
        done_bits.push_back(int'(bus.msg_bits));
        done_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic clear_logs();
    log_vb.delete(); log_vbc.delete();
    done_gid.delete(); done_bits.delete(); done_cyc.delete();
    fin_cnt = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    gate = '1; stall_in = 0; rst_in = 1;
    cycle();
    rst_in = 0;
    clear_logs();
  endtask

  task automatic run_idle(int lim);
    int n;
    bit pend;
    n = 0;
    pend = 1;
    while (pend && n < lim) begin
      cycle();
      n++;
      pend = (m_owner >= 0);
      for (int i = 0; i < N; i++) if (q[i].size() > 0) pend = 1;
    end
    chk("run_timeout", 64'(n < lim), 64'd1);
  endtask

  function automatic int qat(int k, int which);
    case (which)
      0: return (log_vb.size() > k) ? log_vb[k] : -1;
      1: return (done_gid.size() > k) ? done_gid[k] : -1;
      2: return (done_bits.size() > k) ? done_bits[k] : -1;
      default: return (done_cyc.size() > k) ? done_cyc[k] : -1;
    endcase
  endfunction

  initial begin
    int s;
    int nb;
    int r;
    m_owner = -1;
    bus.req_valid = '0; bus.req_data = '0; bus.req_bits = '0;
    bus.req_last = '0; bus.out_stall = 1'b0; rst = 1'b1;

    // three beats from requester 1
    do_reset();
    push(1, 10, 0); push(1, 64, 0); push(1, 5, 1);
    run_idle(60);
    chk("t1_nbeats", 64'(log_vb.size()), 64'd3);
    chk("t1_vb0", 64'(qat(0, 0)), 64'd10);
    chk("t1_vb1", 64'(qat(1, 0)), 64'd64);
    chk("t1_vb2", 64'(qat(2, 0)), 64'd5);
    if (log_vbc.size() == 3)
      chk("t1_consec", 64'(log_vbc[2] - log_vbc[0]), 64'd2);
    chk("t1_gid", 64'(qat(0, 1)), 64'd1);
    chk("t1_bits", 64'(qat(0, 2)), 64'd79);
    chk("t1_fin", 64'(fin_cnt), 64'd1);
    chk("t1_words", 64'((qat(0, 2) + 63) / 64), 64'd2);

    // round robin and wrap
    do_reset();
    push(0, 8, 1); push(2, 9, 1);
    run_idle(60);
    chk("t2_first", 64'(qat(0, 1)), 64'd0);
    chk("t2_second", 64'(qat(1, 1)), 64'd2);
    clear_logs();
    push(0, 3, 1); push(3, 4, 1);
    run_idle(60);
    chk("t2_wrap_a", 64'(qat(0, 1)), 64'd3);
    chk("t2_wrap_b", 64'(qat(1, 1)), 64'd0);

    // stall held mid-message
    do_reset();
    push(1, 8, 0); push(1, 16, 0); push(1, 24, 0);
    push(1, 32, 0); push(1, 40, 1);
    repeat (3) cycle();
    stall_in = 1;
    repeat (4) cycle();
    stall_in = 0;
    run_idle(60);
    chk("t3_nbeats", 64'(log_vb.size()), 64'd5);
    s = 0;
    foreach (log_vb[k]) s += log_vb[k];
    chk("t3_sum", 64'(s), 64'd120);
    chk("t3_bits", 64'(qat(0, 2)), 64'd120);

    // oversize beat
    do_reset();
    push(3, 20, 0); push(3, 70, 0); push(3, 12, 1);
    run_idle(60);
    chk("t4_err", 64'(bus.err_len), 64'd1);
    chk("t4_bits", 64'(qat(0, 2)), 64'd32);
    chk("t4_done", 64'(done_gid.size()), 64'd1);
    push(0, 5, 1);
    run_idle(60);
    chk("t4_sticky", 64'(bus.err_len), 64'd1);

    // reset in the middle of a message
    do_reset();
    push(2, 11, 0); push(2, 12, 0); push(2, 13, 0); push(2, 14, 1);
    repeat (3) cycle();
    rst_in = 1;
    cycle();
    rst_in = 0;
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_vb", 64'(bus.pk_valid_bits), 64'd0);
    q[2].delete();
    repeat (6) cycle();
    chk("t5_nofin", 64'(fin_cnt), 64'd0);
    clear_logs();
    push(2, 7, 1);
    run_idle(60);
    chk("t5_gid", 64'(qat(0, 1)), 64'd2);
    chk("t5_bits", 64'(qat(0, 2)), 64'd7);

    // all requesters with single-beat messages
    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, 1 + i, 1); push(i, 2 + i, 1);
    end
    run_idle(200);
    for (int k = 0; k < 5; k++)
      chk("t6_order", 64'(qat(k, 1)), 64'(k % N));
    for (int k = 0; k < 4; k++)
      chk("t6_period", 64'(qat(k + 1, 3) - qat(k, 3)), 64'd6);

    // random traffic
    do_reset();
    repeat (4000) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() == 0 && $urandom_range(7) == 0) begin
          nb = $urandom_range(4, 1);
          for (int k = 0; k < nb; k++) begin
            r = ($urandom_range(19) == 0) ? $urandom_range(127, 65)
                                          : $urandom_range(64);
            push(i, r, k == nb - 1);
          end
        end
        gate[i] = ($urandom_range(9) != 0);
      end
      stall_in = ($urandom_range(7) == 0);
      rst_in = ($urandom_range(999) == 0);
      cycle();
    end
    gate = '1; stall_in = 0; rst_in = 0;
    run_idle(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
